// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - RV32/RV64 immediate decoder with a 2-entry output FIFO (output register + skid)
module imm_gen_pipe #(
    parameter int XLEN        = 32,
    parameter bit EN_CSR_ZIMM = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic            out_illegal
);

    localparam bit IS64 = (XLEN == 64);

    localparam logic [2:0] T_R   = 3'd0;
    localparam logic [2:0] T_I   = 3'd1;
    localparam logic [2:0] T_S   = 3'd2;
    localparam logic [2:0] T_B   = 3'd3;
    localparam logic [2:0] T_U   = 3'd4;
    localparam logic [2:0] T_J   = 3'd5;
    localparam logic [2:0] T_Z   = 3'd6;
    localparam logic [2:0] T_ILL = 3'd7;

    logic [4:0]         opc;
    logic [XLEN-1:0]    dec_imm;
    logic [2:0]         dec_type;
    logic               dec_ill;

    logic signed [11:0] i_field;
    logic signed [11:0] s_field;
    logic signed [12:0] b_field;
    logic signed [31:0] u_field;
    logic signed [20:0] j_field;

    assign opc     = in_inst[6:2];
    assign i_field = in_inst[31:20];
    assign s_field = {in_inst[31:25], in_inst[11:7]};
    assign b_field = {in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign u_field = {in_inst[31:12], 12'b0};
    assign j_field = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    always_comb begin
        dec_type = T_ILL;
        dec_ill  = 1'b1;
        dec_imm  = '0;
        if (in_inst[1:0] == 2'b11) begin
            case (opc)
                5'b01100: begin
                    dec_type = T_R;
                    dec_ill  = 1'b0;
                end
                5'b01110: begin
                    if (IS64) begin
                        dec_type = T_R;
                        dec_ill  = 1'b0;
                    end
                end
                5'b00100, 5'b00000, 5'b11001, 5'b00011: begin
                    dec_type = T_I;
                    dec_ill  = 1'b0;
                    dec_imm  = XLEN'(i_field);
                end
                5'b00110: begin
                    if (IS64) begin
                        dec_type = T_I;
                        dec_ill  = 1'b0;
                        dec_imm  = XLEN'(i_field);
                    end
                end
                5'b11100: begin
                    dec_ill = 1'b0;
                    // funct3[2] selects the CSR immediate forms (csrrwi/csrrsi/csrrci)
                    if (in_inst[14] && EN_CSR_ZIMM) begin
                        dec_type = T_Z;
                        dec_imm  = XLEN'(in_inst[19:15]);
                    end else begin
                        dec_type = T_I;
                        dec_imm  = XLEN'(i_field);
                    end
                end
                5'b01000: begin
                    dec_type = T_S;
                    dec_ill  = 1'b0;
                    dec_imm  = XLEN'(s_field);
                end
                5'b11000: begin
                    dec_type = T_B;
                    dec_ill  = 1'b0;
                    dec_imm  = XLEN'(b_field);
                end
                5'b01101, 5'b00101: begin
                    dec_type = T_U;
                    dec_ill  = 1'b0;
                    dec_imm  = XLEN'(u_field);
                end
                5'b11011: begin
                    dec_type = T_J;
                    dec_ill  = 1'b0;
                    dec_imm  = XLEN'(j_field);
                end
                default: ;
            endcase
        end
    end

    logic [1:0]      count;
    logic [XLEN-1:0] skid_imm;
    logic [2:0]      skid_type;
    logic            skid_ill;
    logic            push;
    logic            pop;

    // Both handshake outputs come straight from the occupancy register.
    assign in_ready  = ~count[1];
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= 2'd0;
            out_imm     <= '0;
            out_type    <= 3'd0;
            out_illegal <= 1'b0;
            skid_imm    <= '0;
            skid_type   <= 3'd0;
            skid_ill    <= 1'b0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        out_imm     <= dec_imm;
                        out_type    <= dec_type;
                        out_illegal <= dec_ill;
                        count       <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        out_imm     <= dec_imm;
                        out_type    <= dec_type;
                        out_illegal <= dec_ill;
                    end else if (push) begin
                        skid_imm  <= dec_imm;
                        skid_type <= dec_type;
                        skid_ill  <= dec_ill;
                        count     <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    // Full: in_ready is low, so only a drain can happen here.
                    if (pop) begin
                        out_imm     <= skid_imm;
                        out_type    <= skid_type;
                        out_illegal <= skid_ill;
                        count       <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32: immediate output width; legal values 32 and 64 only.
REQ-002 Parameter EN_CSR_ZIMM, default 1: 1 = decode the SYSTEM CSR-immediate zimm field; 0 = treat every SYSTEM instruction as I-type.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_inst holds an instruction.
REQ-006 in_ready  output  1  block accepts in_inst this cycle.
REQ-007 in_inst  input  32  raw RV32/RV64 base instruction word.
REQ-008 out_valid  output  1  out_imm/out_type/out_illegal hold a result.
REQ-009 out_ready  input  1  consumer accepts the result this cycle.
REQ-010 out_imm  output  XLEN  extended immediate.
REQ-011 out_type  output  3  format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR-zimm, 7 illegal.
REQ-012 out_illegal  output  1  instruction not decodable by this block.

Function
REQ-013 Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-014 Buffering: 2-entry FIFO (output register plus skid register), occupancy 0..2, results delivered in acceptance order.
REQ-015 Latency: a result accepted with occupancy 0 appears on out_valid the next cycle.
REQ-016 Throughput: one result per cycle while out_ready stays high.
REQ-017 Ready rule: in_ready = (occupancy < 2), registered, with no combinational path from out_ready.
REQ-018 Simultaneous transfers: with occupancy 1 or 2, simultaneous input and output transfers leave occupancy unchanged.
REQ-019 Full buffer: when the FIFO is full, in_inst is ignored and no entry is overwritten.
REQ-020 Hold stability: out_imm/out_type/out_illegal hold stable while out_valid && !out_ready.
REQ-021 Opcode field: opcode = in_inst[6:2]. If in_inst[1:0] != 2'b11, the result is type 7, illegal=1, imm=0.
REQ-022 Type 0 (R): OP (01100) and, when XLEN=64, OP_32 (01110); imm = 0.
REQ-023 Type 1 (I): OP_IMM (00100), LOAD (00000), JALR (11001), MISC_MEM (00011), OP_IMM_32 (00110, XLEN=64 only), and SYSTEM (11100) with funct3[2]=0 or EN_CSR_ZIMM=0; imm = sext(inst[31:20]).
REQ-024 Type 2 (S): STORE (01000); imm = sext({inst[31:25], inst[11:7]}).
REQ-025 Type 3 (B): BRANCH (11000); imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
REQ-026 Type 4 (U): LUI (01101) and AUIPC (00101); imm = sext({inst[31:12], 12'b0}); bit 31 is replicated to XLEN.
REQ-027 Type 5 (J): JAL (11011); imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
REQ-028 Type 6 (CSR-zimm): SYSTEM with funct3[2]=1 and EN_CSR_ZIMM=1; imm = zero-extended inst[19:15].
REQ-029 Other opcodes: any opcode not listed, including 01110/00110 when XLEN=32, gives type 7, illegal=1, imm=0.
REQ-030 Extension rule: all sign extension is from the field's MSB to the full XLEN.
REQ-031 Decode timing: decode is computed on in_inst at acceptance and stored; stored entries never depend on later inputs.

Reset
REQ-032 While rst is high at a clock edge: occupancy becomes 0, out_valid=0, in_ready=1, out_imm=0, out_type=0, out_illegal=0.
REQ-033 Reset mid-operation: buffered entries are discarded, and no stale entry appears after rst deasserts.
REQ-034 Reset input masking: inputs presented during the rst cycle are not accepted.

Verification
REQ-035 XLEN=32, out_ready=1: inst 0xFFF00093 (addi x1,x0,-1) -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_type=1, out_illegal=0.
REQ-036 Branch and CSR-zimm: inst 0xFE000EE3 (beq -4) -> out_imm=0xFFFFFFFC, type 3; inst 0x300FD073 (csrrwi zimm=31) -> out_imm=0x0000001F, type 6.
REQ-037 XLEN=64: inst 0x800000B7 (lui) -> out_imm=0xFFFFFFFF80000000, type 4; inst 0x0000003B (OP_32) -> type 0, imm=0.
REQ-038 Illegal encodings: inst 0x00000000 -> type 7, out_illegal=1, out_imm=0; the same result holds for inst 0x0000003B when XLEN=32.
REQ-039 Backpressure: out_ready=0, in_valid=1 on three consecutive instructions A,B,C -> A and B accepted, in_ready=0 from the cycle after B's acceptance, C held; out_ready=1 -> A, B, C emitted in order, one per cycle.
REQ-040 Reset with full buffer: rst pulsed for one cycle with 2 entries buffered -> the next cycle shows out_valid=0 and in_ready=1, and nothing is emitted until a new acceptance.
